// File: rtl/l2_msg_issue_arbiter_if.sv
// Handshake bundle between the NoC1/NoC3 input queues, the L2 issue slot and
// the pipeline commit port.
interface l2_msg_issue_arbiter_if #(
    parameter int TAG_W  = 26,
    parameter int SRC_W  = 6,
    parameter int TYPE_W = 8,
    parameter int DATA_W = 64,
    parameter int SLOTS  = 4
);
    localparam int ID_W  = $clog2(SLOTS);
    localparam int CNT_W = ID_W + 1;

    logic              msg1_valid;
    logic              msg1_ready;
    logic [TYPE_W-1:0] msg1_type;
    logic [SRC_W-1:0]  msg1_source;
    logic [TAG_W-1:0]  msg1_tag;
    logic [DATA_W-1:0] msg1_data;

    logic              msg3_valid;
    logic              msg3_ready;
    logic [TYPE_W-1:0] msg3_type;
    logic [SRC_W-1:0]  msg3_source;
    logic [TAG_W-1:0]  msg3_tag;
    logic [DATA_W-1:0] msg3_data;

    logic              issue_valid;
    logic              issue_ready;
    logic              issue_sel;
    logic [TYPE_W-1:0] issue_type;
    logic [SRC_W-1:0]  issue_source;
    logic [TAG_W-1:0]  issue_tag;
    logic [DATA_W-1:0] issue_data;
    logic [ID_W-1:0]   issue_id;

    logic              retire_valid;
    logic [ID_W-1:0]   retire_id;
    logic [CNT_W-1:0]  inflight_cnt;
    logic              err_retire;

    // Arbiter side.
    modport slave (
        input  msg1_valid, msg1_type, msg1_source, msg1_tag, msg1_data,
        output msg1_ready,
        input  msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data,
        output msg3_ready,
        output issue_valid, issue_sel, issue_type, issue_source, issue_tag,
        output issue_data, issue_id,
        input  issue_ready,
        input  retire_valid, retire_id,
        output inflight_cnt, err_retire
    );

    // Queue / pipeline side.
    modport master (
        output msg1_valid, msg1_type, msg1_source, msg1_tag, msg1_data,
        input  msg1_ready,
        output msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data,
        input  msg3_ready,
        input  issue_valid, issue_sel, issue_type, issue_source, issue_tag,
        input  issue_data, issue_id,
        output issue_ready,
        output retire_valid, retire_id,
        input  inflight_cnt, err_retire
    );
endinterface

// File: rtl/l2_msg_issue_arbiter.sv
// L2 pipeline entry arbiter: picks NoC1 request or NoC3 response into one issue
// register, tracks in-flight slots, blocks tag hazards and bounds starvation.
module l2_msg_issue_arbiter #(
    parameter int TAG_W      = 26,
    parameter int SRC_W      = 6,
    parameter int TYPE_W     = 8,
    parameter int DATA_W     = 64,
    parameter int SLOTS      = 4,
    parameter int STARVE_MAX = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    l2_msg_issue_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(SLOTS);
    localparam int CNT_W = ID_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic [SLOTS-1:0]  busy_q, busy_d;
    logic [TAG_W-1:0]  tag_q [SLOTS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              err_q, err_d;

    logic              iss_vld_q, iss_vld_d;
    logic              iss_sel_q, iss_sel_d;
    logic [TYPE_W-1:0] iss_type_q, iss_type_d;
    logic [SRC_W-1:0]  iss_src_q, iss_src_d;
    logic [TAG_W-1:0]  iss_tag_q, iss_tag_d;
    logic [DATA_W-1:0] iss_data_q, iss_data_d;
    logic [ID_W-1:0]   iss_id_q, iss_id_d;

    logic              free_any, hazard, can_load, starve_hit;
    logic              m1_elig, m3_elig, gnt1, gnt3, accept, ret_hit;
    logic [ID_W-1:0]   alloc_id;

    // Hazard is checked against every busy slot, responses included.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (busy_q[i] && (tag_q[i] == bus.msg1_tag)) hazard = 1'b1;
        end
    end

    // Descending scan so the last hit is the lowest free index.
    always_comb begin
        alloc_id = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!busy_q[i]) alloc_id = ID_W'(i);
        end
    end

    assign free_any   = ~&busy_q;
    assign can_load   = !iss_vld_q || bus.issue_ready;
    assign starve_hit = (starve_q == STV_W'(STARVE_MAX));
    assign m1_elig    = bus.msg1_valid && free_any && !hazard;
    assign m3_elig    = bus.msg3_valid && free_any;
    assign gnt1       = rst_n && can_load && m1_elig && (!m3_elig || starve_hit);
    assign gnt3       = rst_n && can_load && m3_elig && !gnt1;
    assign accept     = gnt1 || gnt3;
    assign ret_hit    = bus.retire_valid && busy_q[bus.retire_id];

    always_comb begin
        busy_d = busy_q;
        if (accept)  busy_d[alloc_id] = 1'b1;
        if (ret_hit) busy_d[bus.retire_id] = 1'b0;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, accept} - {{(CNT_W-1){1'b0}}, ret_hit};
        err_d = err_q || (bus.retire_valid && !busy_q[bus.retire_id]);

        starve_d = starve_q;
        if (gnt1)                               starve_d = '0;
        else if (m1_elig && gnt3 && !starve_hit) starve_d = starve_q + 1'b1;
    end

    always_comb begin
        iss_vld_d  = iss_vld_q;
        iss_sel_d  = iss_sel_q;
        iss_type_d = iss_type_q;
        iss_src_d  = iss_src_q;
        iss_tag_d  = iss_tag_q;
        iss_data_d = iss_data_q;
        iss_id_d   = iss_id_q;
        if (accept) begin
            iss_vld_d  = 1'b1;
            iss_sel_d  = gnt3;
            iss_type_d = gnt3 ? bus.msg3_type   : bus.msg1_type;
            iss_src_d  = gnt3 ? bus.msg3_source : bus.msg1_source;
            iss_tag_d  = gnt3 ? bus.msg3_tag    : bus.msg1_tag;
            iss_data_d = gnt3 ? bus.msg3_data   : bus.msg1_data;
            iss_id_d   = alloc_id;
        end else if (bus.issue_ready) begin
            iss_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q     <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            err_q      <= 1'b0;
            iss_vld_q  <= 1'b0;
            iss_sel_q  <= 1'b0;
            iss_type_q <= '0;
            iss_src_q  <= '0;
            iss_tag_q  <= '0;
            iss_data_q <= '0;
            iss_id_q   <= '0;
        end else begin
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            err_q      <= err_d;
            iss_vld_q  <= iss_vld_d;
            iss_sel_q  <= iss_sel_d;
            iss_type_q <= iss_type_d;
            iss_src_q  <= iss_src_d;
            iss_tag_q  <= iss_tag_d;
            iss_data_q <= iss_data_d;
            iss_id_q   <= iss_id_d;
        end
    end

    // Tag storage is qualified by busy_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) tag_q[alloc_id] <= iss_tag_d;
    end

    assign bus.msg1_ready   = gnt1;
    assign bus.msg3_ready   = gnt3;
    assign bus.issue_valid  = iss_vld_q;
    assign bus.issue_sel    = iss_sel_q;
    assign bus.issue_type   = iss_type_q;
    assign bus.issue_source = iss_src_q;
    assign bus.issue_tag    = iss_tag_q;
    assign bus.issue_data   = iss_data_q;
    assign bus.issue_id     = iss_id_q;
    assign bus.inflight_cnt = cnt_q;
    assign bus.err_retire   = err_q;
endmodule

// File: tb/tb_l2_msg_issue_arbiter.sv
// Directed bench for l2_msg_issue_arbiter with an expected-issue queue.
module tb_l2_msg_issue_arbiter;
    localparam int TAG_W = 26, SRC_W = 6, TYPE_W = 8, DATA_W = 64, SLOTS = 4, STARVE_MAX = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_msg_issue_arbiter_if #(.TAG_W(TAG_W), .SRC_W(SRC_W), .TYPE_W(TYPE_W),
                              .DATA_W(DATA_W), .SLOTS(SLOTS)) bus ();

    l2_msg_issue_arbiter #(.TAG_W(TAG_W), .SRC_W(SRC_W), .TYPE_W(TYPE_W), .DATA_W(DATA_W),
                           .SLOTS(SLOTS), .STARVE_MAX(STARVE_MAX)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic              sel;
        logic [TYPE_W-1:0] typ;
        logic [SRC_W-1:0]  src;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [1:0]        id;
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic sel, input logic [1:0] id);
        rec_t r;
        r.sel  = sel;
        r.typ  = sel ? bus.msg3_type   : bus.msg1_type;
        r.src  = sel ? bus.msg3_source : bus.msg1_source;
        r.tag  = sel ? bus.msg3_tag    : bus.msg1_tag;
        r.data = sel ? bus.msg3_data   : bus.msg1_data;
        r.id   = id;
        return r;
    endfunction

    task automatic set1(input logic v, input logic [TAG_W-1:0] tag);
        bus.msg1_valid  = v;
        bus.msg1_tag    = tag;
        bus.msg1_type   = 8'($urandom);
        bus.msg1_source = 6'($urandom);
        bus.msg1_data   = {$urandom, $urandom};
    endtask

    task automatic set3(input logic v, input logic [TAG_W-1:0] tag);
        bus.msg3_valid  = v;
        bus.msg3_tag    = tag;
        bus.msg3_type   = 8'($urandom);
        bus.msg3_source = 6'($urandom);
        bus.msg3_data   = {$urandom, $urandom};
    endtask

    task automatic ret(input logic v, input logic [1:0] id);
        bus.retire_valid = v;
        bus.retire_id    = id;
    endtask

    // Check the ready pair for this cycle, queue what should be issued, advance.
    task automatic cyc(input string name, input logic e1, input logic e3, input logic [1:0] eid);
        @(negedge clk);
        chk({name, ".m1rdy"}, bus.msg1_ready, e1);
        chk({name, ".m3rdy"}, bus.msg3_ready, e3);
        if (e1) exp_q.push_back(mk(1'b0, eid));
        if (e3) exp_q.push_back(mk(1'b1, eid));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (rst_n && bus.issue_valid && bus.issue_ready) begin
            if (exp_q.size() == 0) begin
                chk("issue.unexpected", bus.issue_valid, 1'b0);
            end else begin
                r = exp_q.pop_front();
                chk("issue.rec", {bus.issue_sel, bus.issue_type, bus.issue_source,
                                  bus.issue_tag, bus.issue_data, bus.issue_id}, r);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set1(1'b0, '0);
        set3(1'b0, '0);
        ret(1'b0, 2'd0);
        bus.issue_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset: readies held low even with both sources valid
        set1(1'b1, 26'h100);
        set3(1'b1, 26'h200);
        @(negedge clk);
        chk("rst.m1rdy", bus.msg1_ready, 1'b0);
        chk("rst.m3rdy", bus.msg3_ready, 1'b0);
        chk("rst.ivld", bus.issue_valid, 1'b0);
        chk("rst.itag", bus.issue_tag, '0);
        chk("rst.cnt", bus.inflight_cnt, 3'd0);
        chk("rst.err", bus.err_retire, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Test 1: response wins, request follows
        cyc("t1.c0", 1'b0, 1'b1, 2'd0);
        chk("t1.cnt1", bus.inflight_cnt, 3'd1);
        set3(1'b0, '0);
        cyc("t1.c1", 1'b1, 1'b0, 2'd1);
        set1(1'b0, '0);
        chk("t1.cnt2", bus.inflight_cnt, 3'd2);
        ret(1'b1, 2'd0); cyc("t1.r0", 1'b0, 1'b0, 2'd0);
        ret(1'b1, 2'd1); cyc("t1.r1", 1'b0, 1'b0, 2'd0);
        ret(1'b0, 2'd0);
        chk("t1.cnt0", bus.inflight_cnt, 3'd0);

        // Test 2: tag hazard blocks msg1 until slot 0 retires
        set1(1'b1, 26'h100);
        cyc("t2.a", 1'b1, 1'b0, 2'd0);
        set1(1'b1, 26'h100);
        set3(1'b1, 26'h300);
        cyc("t2.h0", 1'b0, 1'b1, 2'd1);
        cyc("t2.h1", 1'b0, 1'b1, 2'd2);
        set3(1'b0, '0);
        cyc("t2.h2", 1'b0, 1'b0, 2'd0);
        ret(1'b1, 2'd0);
        cyc("t2.retcyc", 1'b0, 1'b0, 2'd0);
        ret(1'b0, 2'd0);
        cyc("t2.go", 1'b1, 1'b0, 2'd0);
        set1(1'b0, '0);
        chk("t2.cnt3", bus.inflight_cnt, 3'd3);
        for (int k = 0; k < 3; k++) begin
            ret(1'b1, 2'(k));
            cyc("t2.drain", 1'b0, 1'b0, 2'd0);
        end
        ret(1'b0, 2'd0);
        chk("t2.cnt0", bus.inflight_cnt, 3'd0);

        // Test 3: eight response wins, then the starved request is forced in
        for (int k = 0; k < 8; k++) begin
            set1(1'b1, 26'h500);
            set3(1'b1, 26'h600);
            ret(k > 0, 2'((k + 1) % 2));
            cyc($sformatf("t3.k%0d", k), 1'b0, 1'b1, 2'(k % 2));
            chk($sformatf("t3.cnt%0d", k), bus.inflight_cnt, 3'd1);
        end
        set3(1'b1, 26'h600);
        ret(1'b1, 2'd1);
        cyc("t3.m1win", 1'b1, 1'b0, 2'd0);
        chk("t3.cntw", bus.inflight_cnt, 3'd1);
        set1(1'b1, 26'h501);
        set3(1'b1, 26'h600);
        ret(1'b1, 2'd0);
        cyc("t3.cleared", 1'b0, 1'b1, 2'd1);
        set1(1'b0, '0);
        set3(1'b0, '0);
        ret(1'b1, 2'd1);
        cyc("t3.idle", 1'b0, 1'b0, 2'd0);
        ret(1'b0, 2'd0);
        chk("t3.cnt0", bus.inflight_cnt, 3'd0);

        // Test 4: fill all slots, then reuse the one retired
        for (int k = 0; k < 4; k++) begin
            set3(1'b1, 26'h800 + 26'(k));
            cyc($sformatf("t4.fill%0d", k), 1'b0, 1'b1, 2'(k));
        end
        set3(1'b1, 26'h804);
        set1(1'b1, 26'h900);
        cyc("t4.full", 1'b0, 1'b0, 2'd0);
        chk("t4.cnt4", bus.inflight_cnt, 3'd4);
        ret(1'b1, 2'd2);
        cyc("t4.retcyc", 1'b0, 1'b0, 2'd0);
        ret(1'b0, 2'd0);
        cyc("t4.realloc", 1'b0, 1'b1, 2'd2);
        set1(1'b0, '0);
        set3(1'b0, '0);
        chk("t4.cnt4b", bus.inflight_cnt, 3'd4);
        for (int k = 0; k < 4; k++) begin
            ret(1'b1, 2'(k));
            cyc("t4.drain", 1'b0, 1'b0, 2'd0);
        end
        ret(1'b0, 2'd0);
        chk("t4.cnt0", bus.inflight_cnt, 3'd0);

        // Test 5: stalled issue register holds, then resumes without a bubble
        bus.issue_ready = 1'b0;
        set3(1'b1, 26'hA00);
        cyc("t5.load", 1'b0, 1'b1, 2'd0);
        set3(1'b1, 26'hA01);
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("t5.stall%0d", k), 1'b0, 1'b0, 2'd0);
            chk("t5.vld", bus.issue_valid, 1'b1);
            chk("t5.tag", bus.issue_tag, 26'hA00);
        end
        bus.issue_ready = 1'b1;
        cyc("t5.resume", 1'b0, 1'b1, 2'd1);
        set3(1'b0, '0);
        chk("t5.nobubble.vld", bus.issue_valid, 1'b1);
        chk("t5.nobubble.tag", bus.issue_tag, 26'hA01);
        ret(1'b1, 2'd0); cyc("t5.r0", 1'b0, 1'b0, 2'd0);
        ret(1'b1, 2'd1); cyc("t5.r1", 1'b0, 1'b0, 2'd0);
        ret(1'b0, 2'd0);
        chk("t5.cnt0", bus.inflight_cnt, 3'd0);

        // Test 6: retire of a free slot is sticky; reset mid-traffic clears all
        ret(1'b1, 2'd3);
        cyc("t6.badret", 1'b0, 1'b0, 2'd0);
        ret(1'b0, 2'd0);
        chk("t6.err1", bus.err_retire, 1'b1);
        chk("t6.cntbad", bus.inflight_cnt, 3'd0);
        cyc("t6.hold", 1'b0, 1'b0, 2'd0);
        chk("t6.err1b", bus.err_retire, 1'b1);
        set3(1'b1, 26'hB00);
        cyc("t6.pre", 1'b0, 1'b1, 2'd0);
        bus.issue_ready = 1'b0;
        set3(1'b1, 26'hB01);
        cyc("t6.pend", 1'b0, 1'b0, 2'd0);
        chk("t6.prevld", bus.issue_valid, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        cyc("t6.rst", 1'b0, 1'b0, 2'd0);
        chk("t6.ivld", bus.issue_valid, 1'b0);
        chk("t6.cnt", bus.inflight_cnt, 3'd0);
        chk("t6.err0", bus.err_retire, 1'b0);
        rst_n = 1'b1;
        bus.issue_ready = 1'b1;
        set3(1'b0, '0);
        set1(1'b1, 26'h100);
        cyc("t6.post", 1'b1, 1'b0, 2'd0);
        set1(1'b0, '0);
        cyc("t6.drain", 1'b0, 1'b0, 2'd0);
        chk("t6.cnt1", bus.inflight_cnt, 3'd1);

        chk("end.q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
